// File: rtl/gpu_mem_pkg.sv
// Shared memory-scheduler types: FSM state encoding and op constants.
package gpu_mem_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RESPOND = 2'd2
  } sched_state_e;

  localparam logic MEM_OP_READ  = 1'b0;
  localparam logic MEM_OP_WRITE = 1'b1;

endpackage

// File: rtl/rr_age_picker.sv
// Combinational round-robin picker with an age-based starvation override.
// Starved requesters (age == AGE_LIMIT) win, lowest index first.
module rr_age_picker #(
  parameter int NUM_REQ   = 4,
  parameter int AGE_LIMIT = 15,
  parameter int AGE_W     = $clog2(AGE_LIMIT + 1),
  parameter int IDX_W     = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]            valid,
  input  logic [NUM_REQ-1:0][AGE_W-1:0] ages,
  input  logic [IDX_W-1:0]              rr_ptr,
  output logic                          grant_valid,
  output logic [IDX_W-1:0]              grant_idx
);

  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(AGE_LIMIT);

  logic             starved_any;
  logic [IDX_W-1:0] starved_idx;
  logic [IDX_W-1:0] rr_idx;

  always_comb begin
    int j;
    starved_any = 1'b0;
    starved_idx = '0;
    rr_idx      = '0;
    j           = 0;
    // Descending scans: the last hit written is the lowest index / nearest offset.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (valid[i] && ages[i] == AGE_MAX) begin
        starved_any = 1'b1;
        starved_idx = IDX_W'(i);
      end
    end
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      j = (int'(rr_ptr) + k) % NUM_REQ;
      if (valid[j]) rr_idx = IDX_W'(j);
    end
    grant_valid = |valid;
    grant_idx   = starved_any ? starved_idx : rr_idx;
  end

endmodule

// File: rtl/mem_txn_scheduler.sv
// One-outstanding memory transaction scheduler for NUM_REQ requesters.
// Optional memory-ready watchdog enabled by defining MEM_TIMEOUT_EN.
module mem_txn_scheduler
  import gpu_mem_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_BITS      = 8,
  parameter int DATA_BITS      = 8,
  parameter int AGE_LIMIT      = 15,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_REQ-1:0]                  req_valid,
  input  logic [NUM_REQ-1:0]                  req_write,
  input  logic [NUM_REQ-1:0][ADDR_BITS-1:0]   req_addr,
  input  logic [NUM_REQ-1:0][DATA_BITS-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]                  req_ready,
  output logic [NUM_REQ-1:0]                  rsp_valid,
  output logic [NUM_REQ-1:0][DATA_BITS-1:0]   rsp_rdata,
  output logic [NUM_REQ-1:0]                  rsp_err,
  input  logic [NUM_REQ-1:0]                  rsp_ack,
  output logic                                mem_read_valid,
  output logic [ADDR_BITS-1:0]                mem_read_address,
  input  logic                                mem_read_ready,
  input  logic [DATA_BITS-1:0]                mem_read_data,
  output logic                                mem_write_valid,
  output logic [ADDR_BITS-1:0]                mem_write_address,
  output logic [DATA_BITS-1:0]                mem_write_data,
  input  logic                                mem_write_ready,
  output logic                                busy
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int AGE_W = $clog2(AGE_LIMIT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(AGE_LIMIT);
  localparam logic [NUM_REQ-1:0] ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

  sched_state_e                state, state_nx;
  logic [IDX_W-1:0]            gnt_q, rr_ptr;
  logic                        op_q;
  logic [ADDR_BITS-1:0]        addr_q;
  logic [DATA_BITS-1:0]        wdata_q, rdata_q;
  logic                        err_q;
  logic [NUM_REQ-1:0][AGE_W-1:0] age;
  logic [NUM_REQ-1:0]          ready_q;

  logic                        pick_valid;
  logic [IDX_W-1:0]            pick_idx;
  logic                        grant_fire, mem_done, tmo_hit;

  rr_age_picker #(
    .NUM_REQ  (NUM_REQ),
    .AGE_LIMIT(AGE_LIMIT),
    .AGE_W    (AGE_W),
    .IDX_W    (IDX_W)
  ) u_picker (
    .valid      (req_valid),
    .ages       (age),
    .rr_ptr     (rr_ptr),
    .grant_valid(pick_valid),
    .grant_idx  (pick_idx)
  );

  // Only the ready matching the latched op counts.
  assign mem_done = (op_q == MEM_OP_READ) ? mem_read_ready : mem_write_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx   = state;
    grant_fire = 1'b0;
    case (state)
      IDLE: begin
        if (pick_valid) begin
          grant_fire = 1'b1;
          state_nx   = ISSUE;
        end
      end
      ISSUE:   if (mem_done || tmo_hit) state_nx = RESPOND;
      RESPOND: if (rsp_ack[gnt_q]) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt_q   <= '0;
      rr_ptr  <= '0;
      op_q    <= MEM_OP_READ;
      addr_q  <= '0;
      wdata_q <= '0;
      ready_q <= '0;
    end else begin
      ready_q <= grant_fire ? (ONE << pick_idx) : '0;
      if (grant_fire) begin
        gnt_q   <= pick_idx;
        op_q    <= req_write[pick_idx];
        addr_q  <= req_addr[pick_idx];
        wdata_q <= req_wdata[pick_idx];
        rr_ptr  <= (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
      end
    end
  end

  // Age clears on the grant edge and on the accept-pulse cycle, so a
  // requester still holding valid while it sees req_ready does not age.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      age <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!req_valid[i] || (grant_fire && pick_idx == IDX_W'(i)) || ready_q[i])
          age[i] <= '0;
        else if (age[i] != AGE_MAX)
          age[i] <= age[i] + 1'b1;
      end
    end
  end

  // A ready in the expiry cycle wins over the timeout.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else if (state == ISSUE) begin
      if (mem_done) begin
        rdata_q <= (op_q == MEM_OP_READ) ? mem_read_data : '0;
        err_q   <= 1'b0;
      end else if (tmo_hit) begin
        rdata_q <= '0;
        err_q   <= 1'b1;
      end
    end
  end

`ifdef MEM_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TMO_W-1:0] tmo_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)               tmo_cnt <= '0;
    else if (state == ISSUE) tmo_cnt <= tmo_cnt + 1'b1;
    else                     tmo_cnt <= '0;
  end

  assign tmo_hit = (state == ISSUE) && (tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1)) && !mem_done;
`else
  // No watchdog: ISSUE waits for memory indefinitely (expression is constant 0).
  assign tmo_hit = (TIMEOUT_CYCLES < 0);
`endif

  assign req_ready         = ready_q;
  assign busy              = (state != IDLE);
  assign mem_read_valid    = (state == ISSUE) && (op_q == MEM_OP_READ);
  assign mem_write_valid   = (state == ISSUE) && (op_q == MEM_OP_WRITE);
  assign mem_read_address  = mem_read_valid  ? addr_q  : '0;
  assign mem_write_address = mem_write_valid ? addr_q  : '0;
  assign mem_write_data    = mem_write_valid ? wdata_q : '0;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_rsp
    assign rsp_valid[i] = (state == RESPOND) && (gnt_q == IDX_W'(i));
    assign rsp_rdata[i] = rsp_valid[i] ? rdata_q : '0;
`ifdef MEM_TIMEOUT_EN
    assign rsp_err[i]   = rsp_valid[i] && err_q;
`else
    assign rsp_err[i]   = 1'b0;
`endif
  end

endmodule

// File: doc/mem_txn_scheduler.md
# mem_txn_scheduler

Single-channel memory transaction scheduler that shares one memory port between NUM_REQ requesters (LSUs, fetchers or the DMA engine). Requests are accepted with a one-cycle valid/ready handshake, and only one transaction is outstanding at a time. Grants are round-robin, with an age-based starvation override. The block sits between a requester cluster and one channel of the memory system, and drives the same mem_read_*/mem_write_* signalling the memory channels expect.

## Interface
- NUM_REQ, 4, number of requesters (≥2)
- ADDR_BITS, 8, address width
- DATA_BITS, 8, data width
- AGE_LIMIT, 15, waiting cycles at which a requester becomes starved (≥1)
- TIMEOUT_CYCLES, 64, memory-ready watchdog limit (used only with MEM_TIMEOUT_EN)
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NUM_REQ  request pending per requester
- req_write  in  NUM_REQ  1 = write, 0 = read
- req_addr  in  NUM_REQ×ADDR_BITS  request address
- req_wdata  in  NUM_REQ×DATA_BITS  write data
- req_ready  out  NUM_REQ  one-cycle accept pulse
- rsp_valid  out  NUM_REQ  response pending, held until acked
- rsp_rdata  out  NUM_REQ×DATA_BITS  read data, valid with rsp_valid
- rsp_err  out  NUM_REQ  transaction timed out
- rsp_ack  in  NUM_REQ  requester consumes response
- mem_read_valid / mem_read_address  out  1 / ADDR_BITS  read request to memory
- mem_read_ready / mem_read_data  in  1 / DATA_BITS  read completion
- mem_write_valid / mem_write_address / mem_write_data  out  1 / ADDR_BITS / DATA_BITS  write request to memory
- mem_write_ready  in  1  write completion
- busy  out  1  state ≠ IDLE

## Operation
- States:
  - IDLE → ISSUE on a grant.
  - ISSUE → RESPOND on the matching mem ready, or on timeout.
  - RESPOND → IDLE when rsp_ack[g] is sampled high.
- Grant is evaluated only in IDLE, over requesters with req_valid=1:
  - If any age[i]==AGE_LIMIT, grant the lowest such index.
  - Otherwise grant the first valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
  - On every grant, rr_ptr ← (g+1) mod NUM_REQ. This includes starvation grants.
- Age counters:
  - Width is $clog2(AGE_LIMIT+1), saturating.
  - age[i] increments each cycle req_valid[i]=1 and i is not accepted this cycle.
  - age[i] clears on accept or when req_valid[i]=0.
- On grant, the block latches g, req_write[g], req_addr[g] and req_wdata[g]. Requester inputs are don't-care after the accept pulse.
- ISSUE:
  - For a read, assert mem_read_valid with the latched address.
  - For a write, assert mem_write_valid with the latched address and data.
  - Only the ready signal matching the op is honoured. The other is ignored.
- RESPOND: rsp_valid[g]=1, rsp_rdata[g] holds the captured mem_read_data (0 for writes), and rsp_err[g] is set on timeout.
- Requester g may reassert req_valid while its rsp_valid is pending. It is not granted until the block returns to IDLE.
- Reset, including mid-transaction:
  - State → IDLE; rr_ptr, ages, latched fields and all outputs clear to 0.
  - An in-flight transaction is dropped silently.

## Timing
- Registered grant: requests sampled in IDLE at cycle t give req_ready[g] and mem_*_valid high at t+1. State is ISSUE from t+1.
- mem ready sampled at cycle u gives mem_*_valid low and rsp_valid[g] high at u+1. Data is captured at u.
- rsp_ack[g] sampled at cycle v gives rsp_valid[g] low and state IDLE at v+1. The next accept pulse is at v+2 at the earliest.
- Minimum turnaround, with ready and ack both immediate: 3 cycles per transaction.
- req_ready is never high for more than one requester or more than one cycle.
- rsp_ack[i] for a requester with no pending response is ignored.

## Configuration
- MEM_TIMEOUT_EN defined:
  - A counter runs in ISSUE. When it reaches TIMEOUT_CYCLES without the matching ready, mem_*_valid drops and the block enters RESPOND with rsp_err[g]=1 and rsp_rdata[g]=0.
  - A mem ready arriving in the same cycle as expiry wins: the transaction completes normally with no error.
- MEM_TIMEOUT_EN undefined: ISSUE waits indefinitely, no counter is synthesised, and rsp_err stays tied to 0. The port list is unchanged.

## Structure
- Shared package gpu_mem_pkg holds:
  - sched_state_e (IDLE, ISSUE, RESPOND)
  - MEM_OP_READ/MEM_OP_WRITE constants
- Sub-module rr_age_picker: purely combinational. Inputs are valid, ages and rr_ptr; outputs are grant_valid and grant_idx. It is reusable by other arbiters.
- The top level holds the FSM, latches, age counters and the watchdog.

## Test plan
- Single read, requester 2, addr 0x3C, memory ready 2 cycles later with data 0xA5 → req_ready[2] pulse at t+1; rsp_rdata[2]=0xA5 with rsp_valid[2]; rsp_err=0.
- All four requesters hold reads continuously, each acking immediately → grants in order 0,1,2,3,0; no requester waits more than 3 transactions.
- AGE_LIMIT=3; requester 1 requests while requesters 2 and 3 are pending and rr_ptr=2; requester 1 ages to 3 → requester 1 is granted next, ahead of round-robin order.
- Write from requester 0, data 0x5A to 0x10 → mem_write_valid with addr 0x10 and data 0x5A; mem_read_valid stays 0; rsp_rdata[0]=0 on completion.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=8, memory never readies → mem_read_valid drops after 8 ISSUE cycles; rsp_err[g]=1. Without the macro, busy stays 1 for at least 100 cycles.
- reset asserted mid-ISSUE → all outputs 0 asynchronously; after release, a fresh request is granted with rr_ptr=0.
